// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC pipeline: opcode encodings, register index,
// instruction layout and the register-file write command format.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DST_LSB = 10;

  typedef logic [1:0]      reg_idx_t;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD   = 4'b0001;
  localparam op_t OP_SUB   = 4'b0010;
  localparam op_t OP_AND   = 4'b0011;
  localparam op_t OP_INC   = 4'b0100;
  localparam op_t OP_SHL   = 4'b0101;
  localparam op_t OP_SHR   = 4'b0110;
  localparam op_t OP_STORE = 4'b0111;
  localparam op_t OP_LOAD  = 4'b1101;
  localparam op_t OP_LDI   = 4'b1111;

  // The register file's write port reuses the LOAD encoding as its command
  localparam op_t OP_WB_WRITE = OP_LOAD;

  typedef struct packed {
    op_t               op;
    reg_idx_t          dst;
    reg_idx_t          src;
    logic [DATA_W-1:0] imm;
  } instr_t;

  function automatic logic is_alu(op_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_INC, OP_SHL, OP_SHR};
  endfunction

  function automatic logic [INSTR_W-1:0] wb_write_opcode(reg_idx_t dst);
    return {OP_WB_WRITE, dst, 10'b0};
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU for the execute stage; carry holds carry, borrow or shifted-out bit.
module alu8
  import cpu_pkg::*;
(
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (a < b)
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_AND: result = a & b;
      OP_INC: result = a + DATA_W'(1);
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute/write-back stage: operand forwarding, ALU, load/store memory FSM with timeout,
// and a write-back command formatted for the register file's write port.
module execute_stage
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] id_opcode,
  input  logic [DATA_W-1:0]  ra,
  input  logic [DATA_W-1:0]  rb,
  output logic               ex_busy,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_re,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic               wb_we,
  output logic [INSTR_W-1:0] wb_opcode,
  output logic [DATA_W-1:0]  wb_data,
  output logic               flag_z,
  output logic               flag_c,
  output logic               mem_err
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WR = 2'd2
  } state_t;

  state_t            state, next_state;
  instr_t            id_instr, ex_instr;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_a, ex_b;
  logic [CNT_W-1:0]  wait_cnt;
  logic              accept, mem_done, timed_out;
  reg_idx_t          wb_dst;
  logic              fwd_a, fwd_b;
  logic [DATA_W-1:0] op_a, op_b, alu_result;
  logic              alu_carry;

  assign id_instr = id_opcode;
  assign accept   = id_valid && !ex_busy;

  // Bypass the result being written back this cycle; B only for two-operand ops
  assign wb_dst = wb_opcode[DST_LSB +: 2];
  assign fwd_a  = wb_we && (wb_dst == ex_instr.dst);
  assign fwd_b  = wb_we && (wb_dst == ex_instr.src) &&
                  (ex_instr.op inside {OP_ADD, OP_SUB, OP_AND});
  assign op_a   = fwd_a ? wb_data : ex_a;
  assign op_b   = fwd_b ? wb_data : ex_b;

  alu8 u_alu (
    .op     (ex_instr.op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Memory FSM: next state and memory port decode
  always_comb begin
    next_state = state;
    ex_busy    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    timed_out  = 1'b0;
    mem_done   = 1'b0;
    case (state)
      IDLE: begin
        if (id_valid) begin
          if (id_instr.op == OP_LOAD)       next_state = MEM_RD;
          else if (id_instr.op == OP_STORE) next_state = MEM_WR;
        end
      end
      MEM_RD, MEM_WR: begin
        ex_busy   = 1'b1;
        mem_re    = (state == MEM_RD);
        mem_we    = (state == MEM_WR);
        mem_addr  = ex_instr.imm;
        mem_wdata = (state == MEM_WR) ? op_a : '0;
        timed_out = !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
        mem_done  = mem_ready || timed_out;
        if (mem_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_instr <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_instr <= id_instr;
        ex_a     <= ra;
        ex_b     <= rb;
      end else if (state == MEM_WR) begin
        // Keep the forwarded store data once the bypass source has retired
        ex_a <= op_a;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (state != IDLE && !mem_done) wait_cnt <= wait_cnt + CNT_W'(1);
      else                            wait_cnt <= '0;
      if (timed_out) mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we     <= 1'b0;
      wb_opcode <= '0;
      wb_data   <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      wb_we <= 1'b0;
      if (state == MEM_RD && mem_done) begin
        wb_we     <= 1'b1;
        wb_opcode <= wb_write_opcode(ex_instr.dst);
        wb_data   <= mem_ready ? mem_rdata : '0;
      end else if (state == IDLE && ex_valid) begin
        if (is_alu(ex_instr.op)) begin
          wb_we     <= 1'b1;
          wb_opcode <= wb_write_opcode(ex_instr.dst);
          wb_data   <= alu_result;
          flag_z    <= (alu_result == '0);
          flag_c    <= alu_carry;
        end else if (ex_instr.op == OP_LDI) begin
          wb_we     <= 1'b1;
          wb_opcode <= ex_instr;
          wb_data   <= ex_instr.imm;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus a randomized back-to-back ALU/LDI stream
// checked against an architectural register/flag model.
module tb_execute_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid;
  logic [15:0] id_opcode;
  logic [7:0]  ra, rb, mem_rdata;
  logic        mem_ready;
  logic        ex_busy, mem_re, mem_we, wb_we, flag_z, flag_c, mem_err;
  logic [7:0]  mem_addr, mem_wdata, wb_data;
  logic [15:0] wb_opcode;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_z = 1'b0;
  logic exp_c = 1'b0;

  execute_stage #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .ra(ra), .rb(rb), .ex_busy(ex_busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_we(wb_we), .wb_opcode(wb_opcode), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid  = 1'b0;
    id_opcode = '0;
    ra        = '0;
    rb        = '0;
  endtask

  function automatic logic [46:0] all_outs();
    return {ex_busy, mem_addr, mem_wdata, mem_re, mem_we, wb_we, wb_opcode, wb_data,
            flag_z, flag_c, mem_err};
  endfunction

  function automatic void ref_alu(input logic [3:0] op, input int a, input int b,
                                  output int res, output logic c);
    int t;
    res = 0;
    c   = 1'b0;
    case (op)
      4'b0001: begin t = a + b; res = t % 256; c = (t > 255); end
      4'b0010: begin res = (a - b + 256) % 256; c = (a < b); end
      4'b0011: res = a & b;
      4'b0100: res = (a + 1) % 256;
      4'b0101: begin res = (a * 2) % 256; c = (a >= 128); end
      4'b0110: begin res = a / 2; c = ((a % 2) == 1); end
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) tick();
    n_checks++;
    if (all_outs() !== 47'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (all_outs() !== 47'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_ldi_add_chain();
    id_valid = 1'b1; id_opcode = 16'hF0F0; ra = 8'h00; rb = 8'h00; tick();
    id_opcode = 16'hF420; tick();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data, flag_z, flag_c} !== {1'b1, 16'hF0F0, 8'hF0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ldi_r0: got %h expected %h", {wb_we, wb_opcode, wb_data, flag_z, flag_c},
               {1'b1, 16'hF0F0, 8'hF0, 1'b0, 1'b0});
    end
    // R1 still stale in the register file; must be forwarded from write-back
    id_opcode = 16'h1100; ra = 8'hF0; rb = 8'h00; tick();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data} !== {1'b1, 16'hF420, 8'h20}) begin
      n_fail++;
      $display("FAIL ldi_r1: got %h expected %h", {wb_we, wb_opcode, wb_data},
               {1'b1, 16'hF420, 8'h20});
    end
    idle_inputs(); tick();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data, flag_z, flag_c} !== {1'b1, 16'hD000, 8'h10, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_forward: got %h expected %h", {wb_we, wb_opcode, wb_data, flag_z, flag_c},
               {1'b1, 16'hD000, 8'h10, 1'b0, 1'b1});
    end
    tick();
    n_checks++;
    if (wb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_single_pulse: got %b expected 0", wb_we);
    end
    exp_z = 1'b0; exp_c = 1'b1;
  endtask

  task automatic test_sub_shr();
    id_valid = 1'b1; id_opcode = 16'h2B00; ra = 8'h5A; rb = 8'h5A; tick();
    id_opcode = 16'h6C00; ra = 8'h01; rb = 8'h00; tick();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data, flag_z, flag_c} !== {1'b1, 16'hD800, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_equal: got %h expected %h", {wb_we, wb_opcode, wb_data, flag_z, flag_c},
               {1'b1, 16'hD800, 8'h00, 1'b1, 1'b0});
    end
    idle_inputs(); tick();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data, flag_z, flag_c} !== {1'b1, 16'hDC00, 8'h00, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL shr_one: got %h expected %h", {wb_we, wb_opcode, wb_data, flag_z, flag_c},
               {1'b1, 16'hDC00, 8'h00, 1'b1, 1'b1});
    end
    exp_z = 1'b1; exp_c = 1'b1;
  endtask

  task automatic test_load();
    int busy;
    busy = 0;
    id_valid = 1'b1; id_opcode = 16'hD840; ra = 8'h00; rb = 8'h00; tick();
    idle_inputs();
    for (int i = 0; i < 20 && ex_busy; i++) begin
      busy++;
      n_checks++;
      if ({mem_re, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h40}) begin
        n_fail++;
        $display("FAIL load_port: got %h expected %h", {mem_re, mem_we, mem_addr},
                 {1'b1, 1'b0, 8'h40});
      end
      if (busy == 3) begin mem_ready = 1'b1; mem_rdata = 8'hAB; end
      tick();
      mem_ready = 1'b0; mem_rdata = 8'h00;
    end
    n_checks++;
    if (busy != 3) begin
      n_fail++;
      $display("FAIL load_busy_cycles: got %0d expected 3", busy);
    end
    n_checks++;
    if ({wb_we, wb_opcode, wb_data, flag_z, flag_c, mem_re} !==
        {1'b1, 16'hD800, 8'hAB, exp_z, exp_c, 1'b0}) begin
      n_fail++;
      $display("FAIL load_wb: got %h expected %h", {wb_we, wb_opcode, wb_data, flag_z, flag_c, mem_re},
               {1'b1, 16'hD800, 8'hAB, exp_z, exp_c, 1'b0});
    end
    // Stray ready while idle must not produce anything
    mem_ready = 1'b1; mem_rdata = 8'h55; tick();
    mem_ready = 1'b0; mem_rdata = 8'h00;
    n_checks++;
    if ({wb_we, ex_busy, mem_re, mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_ready_ignored: got %b expected 0000", {wb_we, ex_busy, mem_re, mem_we});
    end
  endtask

  task automatic test_store_timeout();
    int we_cycles;
    we_cycles = 0;
    id_valid = 1'b1; id_opcode = 16'hF477; ra = 8'h00; rb = 8'h00; tick();
    // STORE R1 right behind the LDI: store data comes from the bypass
    id_opcode = 16'h7433; ra = 8'h20; tick();
    idle_inputs();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data} !== {1'b1, 16'hF477, 8'h77}) begin
      n_fail++;
      $display("FAIL ldi_before_store: got %h expected %h", {wb_we, wb_opcode, wb_data},
               {1'b1, 16'hF477, 8'h77});
    end
    for (int i = 0; i < 40 && mem_we; i++) begin
      we_cycles++;
      n_checks++;
      if ({mem_addr, mem_wdata, ex_busy, mem_re, mem_err} !== {8'h33, 8'h77, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL store_port: got %h expected %h", {mem_addr, mem_wdata, ex_busy, mem_re, mem_err},
                 {8'h33, 8'h77, 1'b1, 1'b0, 1'b0});
      end
      if (i > 0) begin
        n_checks++;
        if (wb_we !== 1'b0) begin
          n_fail++;
          $display("FAIL store_no_wb: got %b expected 0", wb_we);
        end
      end
      tick();
    end
    n_checks++;
    if (we_cycles != 15) begin
      n_fail++;
      $display("FAIL store_timeout_cycles: got %0d expected 15", we_cycles);
    end
    n_checks++;
    if ({mem_err, wb_we, ex_busy, mem_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL store_timeout_state: got %b expected 1000", {mem_err, wb_we, ex_busy, mem_we});
    end
    id_valid = 1'b1; id_opcode = 16'h1100; ra = 8'h01; rb = 8'hFF; tick();
    idle_inputs(); tick();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data, flag_z, flag_c, mem_err} !==
        {1'b1, 16'hD000, 8'h00, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL add_after_timeout: got %h expected %h",
               {wb_we, wb_opcode, wb_data, flag_z, flag_c, mem_err},
               {1'b1, 16'hD000, 8'h00, 1'b1, 1'b1, 1'b1});
    end
    exp_z = 1'b1; exp_c = 1'b1;
  endtask

  task automatic test_nop();
    id_valid = 1'b1; id_opcode = 16'h1100; ra = 8'hFF; rb = 8'h02; tick();
    id_opcode = 16'h8123; ra = 8'h11; rb = 8'h22; tick();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data, flag_z, flag_c, mem_re, mem_we} !==
        {1'b1, 16'hD000, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_before_nop: got %h expected %h",
               {wb_we, wb_opcode, wb_data, flag_z, flag_c, mem_re, mem_we},
               {1'b1, 16'hD000, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    id_opcode = 16'h1E00; ra = 8'h30; rb = 8'h0F; tick();
    n_checks++;
    if ({wb_we, mem_re, mem_we, ex_busy, flag_z, flag_c} !== 6'b000001) begin
      n_fail++;
      $display("FAIL nop_quiet: got %b expected 000001", {wb_we, mem_re, mem_we, ex_busy, flag_z, flag_c});
    end
    idle_inputs(); tick();
    n_checks++;
    if ({wb_we, wb_opcode, wb_data, flag_z, flag_c} !== {1'b1, 16'hDC00, 8'h3F, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_after_nop: got %h expected %h", {wb_we, wb_opcode, wb_data, flag_z, flag_c},
               {1'b1, 16'hDC00, 8'h3F, 1'b0, 1'b0});
    end
    tick();
    exp_z = 1'b0; exp_c = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  arch [4];
    logic [7:0]  lag  [4];
    logic [3:0]  alu_ops [6];
    logic [3:0]  nop_ops [7];
    logic [3:0]  op;
    logic [1:0]  d, r;
    logic [7:0]  imm;
    logic        v, c, ez, ec, pz, pc;
    logic        pend_we, nxt_we;
    logic [15:0] pend_opc, nxt_opc;
    logic [7:0]  pend_data, nxt_data;
    int          sel, res;
    alu_ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    nop_ops = '{4'h0, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
    for (int k = 0; k < 4; k++) begin
      arch[k] = 8'($urandom);
      lag[k]  = arch[k];
    end
    pend_we = 1'b0; pend_opc = '0; pend_data = '0;
    ez = exp_z; ec = exp_c; pz = exp_z; pc = exp_c;
    for (int s = 0; s <= 300; s++) begin
      nxt_we = 1'b0; nxt_opc = '0; nxt_data = '0;
      if (s < 300) begin
        v   = ($urandom_range(9) != 0);
        sel = $urandom_range(15);
        if (sel < 12)      op = alu_ops[sel % 6];
        else if (sel < 14) op = 4'hF;
        else               op = nop_ops[$urandom_range(6)];
        d = 2'($urandom); r = 2'($urandom); imm = 8'($urandom);
        id_valid = v; id_opcode = {op, d, r, imm};
        // Register file view lags by the instruction issued in the previous cycle
        ra = lag[d]; rb = lag[r];
        lag = arch;
        if (v && op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6}) begin
          ref_alu(op, int'(arch[d]), int'(arch[r]), res, c);
          nxt_we = 1'b1; nxt_opc = {4'hD, d, 10'h000}; nxt_data = 8'(res);
          arch[d] = 8'(res); ez = (res == 0); ec = c;
        end else if (v && op == 4'hF) begin
          nxt_we = 1'b1; nxt_opc = {op, d, r, imm}; nxt_data = imm;
          arch[d] = imm;
        end
      end else begin
        idle_inputs();
        lag = arch;
      end
      tick();
      n_checks++;
      if (wb_we !== pend_we) begin
        n_fail++;
        $display("FAIL rand_wb_we step %0d: got %b expected %b", s, wb_we, pend_we);
      end
      if (pend_we) begin
        n_checks++;
        if ({wb_opcode, wb_data} !== {pend_opc, pend_data}) begin
          n_fail++;
          $display("FAIL rand_wb step %0d: got %h expected %h", s, {wb_opcode, wb_data},
                   {pend_opc, pend_data});
        end
      end
      n_checks++;
      if ({flag_z, flag_c} !== {pz, pc}) begin
        n_fail++;
        $display("FAIL rand_flags step %0d: got %b expected %b", s, {flag_z, flag_c}, {pz, pc});
      end
      pend_we = nxt_we; pend_opc = nxt_opc; pend_data = nxt_data;
      pz = ez; pc = ec;
    end
    exp_z = ez; exp_c = ec;
  endtask

  task automatic test_reset_mid_load();
    id_valid = 1'b1; id_opcode = 16'hD410; ra = 8'h00; rb = 8'h00; tick();
    idle_inputs(); tick();
    n_checks++;
    if ({mem_re, ex_busy, mem_addr} !== {1'b1, 1'b1, 8'h10}) begin
      n_fail++;
      $display("FAIL pre_reset_load: got %h expected %h", {mem_re, ex_busy, mem_addr},
               {1'b1, 1'b1, 8'h10});
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== 47'h0) begin
      n_fail++;
      $display("FAIL reset_mid_load: got %h expected 0", all_outs());
    end
    tick();
    #2 reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ready = 1'b0; mem_rdata = 8'h00;
    n_checks++;
    if (all_outs() !== 47'h0) begin
      n_fail++;
      $display("FAIL load_abandoned: got %h expected 0", all_outs());
    end
  endtask

  initial begin
    test_reset();
    test_ldi_add_chain();
    test_sub_shr();
    test_load();
    test_store_timeout();
    test_nop();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute/write-back stage of the 8-bit RISC pipeline, directly downstream of the 4x8 register file.
- Consumes the register file's Ra/Rb operands and the 16-bit opcode, performs ALU, load, store and load-immediate operations, and drives the data memory port.
- Produces a write-back command (we/opcode/data) in the exact format the register file's write port accepts, and owns the Z/C flags.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles to wait for mem_ready before aborting a memory op.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  opcode/ra/rb from decode are valid.
- id_opcode  in  16  instruction: [15:12] op, [11:10] dest/srcA, [9:8] srcB, [7:0] imm/address.
- ra  in  8  register-file operand A.
- rb  in  8  register-file operand B.
- ex_busy  out  1  stall to upstream; upstream holds id_* while high.
- mem_addr  out  8  data memory address.
- mem_wdata  out  8  store data.
- mem_re  out  1  load request.
- mem_we  out  1  store request.
- mem_rdata  in  8  load data, valid when mem_ready is high.
- mem_ready  in  1  memory completes the current request this cycle.
- wb_we  out  1  register-file write enable.
- wb_opcode  out  16  register-file write opcode.
- wb_data  out  8  register-file write data.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow/shift-out flag.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async): all outputs 0; EX/WB registers invalid; FSM goes to IDLE; wait counter 0. Asserting reset mid-memory-op drops mem_re/mem_we immediately and abandons the op.

Opcode map:
- 0001 ADD: A+B.
- 0010 SUB: A-B.
- 0011 AND: A&B.
- 0100 INC: A+1.
- 0101 SHL: A<<1.
- 0110 SHR: A>>1, logical.
- 0111 STORE: mem[imm] = A.
- 1101 LOAD: dest = mem[imm].
- 1111 LDI: dest = imm.
- All other opcodes are NOPs: no write-back, no memory access, no flag change.

Pipeline and latency:
- The EX register captures id_* on the edge where id_valid=1 and ex_busy=0.
- For ALU ops and LDI, WB registers one edge later: wb_we is high for exactly one cycle, 2 edges after issue.

Write-back format:
- ALU ops: wb_opcode = {4'b1101, dest, 10'b0}, wb_data = result.
- LDI: wb_opcode = EX opcode, wb_data = imm.
- LOAD: wb_opcode = {4'b1101, dest, 10'b0}, wb_data = mem_rdata.

Forwarding:
- If wb_we=1 and the WB dest equals EX opcode[11:10], operand A = wb_data.
- The same rule applies to [9:8] for operand B (ADD/SUB/AND only).
- Otherwise operands come from the registered ra/rb.

Flags (ALU ops only; both flags are registered alongside WB):
- Z = (result == 0).
- C by op:
  - ADD: carry out of bit 7.
  - SUB: borrow, i.e. A<B.
  - SHL: old A[7].
  - SHR: old A[0].
  - AND, INC: C=0.
- All arithmetic is mod 256.

FSM:
- IDLE:
  - ALU/LDI: pass straight to WB.
  - LOAD: go to MEM_RD.
  - STORE: go to MEM_WR.
- MEM_RD: mem_re=1, mem_addr=imm, ex_busy=1.
  - On mem_ready: write back mem_rdata and return to IDLE.
- MEM_WR: mem_we=1, mem_addr=imm, mem_wdata=forwarded A, ex_busy=1.
  - On mem_ready: return to IDLE, no write-back.
- Wait counter: increments each cycle in MEM_RD/MEM_WR.
  - When it reaches MEM_TIMEOUT without mem_ready: set mem_err (sticky until reset).
  - A timed-out LOAD writes back 8'h00; a timed-out STORE is dropped.
  - Then return to IDLE.
- mem_ready in the same cycle as the timeout: treat as success.
- mem_ready outside MEM_RD/MEM_WR is ignored.
- ex_busy is combinational from the state. It is asserted in the capture cycle of a memory op onward; the next instruction is accepted on the edge the FSM returns to IDLE.
- Back-to-back ALU ops: one per cycle, no bubbles.

Decomposition:
- Shared package cpu_pkg: 4-bit opcode constants (OP_ADD…OP_LDI) and the 2-bit register index type. The register file should migrate to cpu_pkg too.
- Sub-module alu8: combinational; inputs op, a, b; outputs result, carry.
- FSM, forwarding and pipeline registers live in execute_stage.

Test Plan:
- Reset: assert reset mid-MEM_RD -> mem_re drops the same cycle; all outputs 0; ex_busy=0.
- LDI then ADD chain: LDI R0,8'hF0; LDI R1,8'h20; ADD R0,R1 with forwarding -> wb_data=8'h10, wb_opcode=16'hD000, flag_c=1, flag_z=0.
- SUB equal operands: A=8'h5A, B=8'h5A -> wb_data=0, flag_z=1, flag_c=0. SHR A=8'h01 -> wb_data=0, flag_c=1, flag_z=1.
- LOAD with mem_ready after 3 cycles: LOAD R2,addr 8'h40, mem_rdata=8'hAB -> mem_addr=8'h40, ex_busy high 3 cycles, wb_we pulse with wb_opcode=16'hD800, wb_data=8'hAB.
- STORE timeout: mem_ready never asserts -> mem_we high for 15 cycles, then mem_err=1 and no wb_we. A following ADD issues normally.
- NOP opcode 1000 between ALU ops -> no wb_we, no memory access, flags unchanged.
